// File: rtl/heap_port_arbiter.sv
// Shares one picorv32-style valid/ready heap RAM port among NREQ requesters.
// Round-robin arbitration, bounded burst lock, mandatory idle gap and a transfer watchdog.
module heap_port_arbiter #(
    parameter int          NREQ      = 3,
    parameter int          MAX_BURST = 16,
    parameter int          TIMEOUT   = 64,
    parameter logic [31:0] ERR_RDATA = 32'hDEAD_BEEF
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ-1:0]   req_lock,
    input  logic [NREQ*32-1:0] req_addr,
    input  logic [NREQ*32-1:0] req_wdata,
    input  logic [NREQ*4-1:0] req_wstrb,
    output logic [NREQ-1:0]   req_ready,
    output logic [31:0]       req_rdata,
    output logic              ram_valid,
    output logic [31:0]       ram_addr,
    output logic [31:0]       ram_wdata,
    output logic [3:0]        ram_wstrb,
    input  logic              ram_ready,
    input  logic [31:0]       ram_rdata,
    output logic [NREQ-1:0]   grant,
    output logic              bus_busy,
    output logic              timeout_err
);

    localparam int IW = (NREQ > 1)      ? $clog2(NREQ)      : 1;
    localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam int WW = (TIMEOUT > 1)   ? $clog2(TIMEOUT)   : 1;

    typedef enum logic [1:0] {IDLE, XFER, GAP} state_e;

    state_e          state_q;
    logic [NREQ-1:0] grant_q;
    logic            ram_valid_q;
    logic [IW-1:0]   rr_ptr_q;
    logic [IW-1:0]   winner_q;
    logic [BW-1:0]   burst_cnt_q;
    logic [WW-1:0]   wd_cnt_q;

    logic [IW-1:0]   pick_d;
    logic            pick_vld_d;
    logic            wd_expired;
    logic            xfer_end;
    logic            done_ok;

    // First pending requester at or above rr_ptr, wrapping at NREQ.
    always_comb begin
        int cand;
        // NOTE: every variable gets a default before any branch so no path can infer a latch.
        cand       = 0;
        pick_d     = '0;
        pick_vld_d = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            cand = (int'(rr_ptr_q) + k) % NREQ;
            if (!pick_vld_d && req_valid[IW'(cand)]) begin
                pick_d     = IW'(cand);
                pick_vld_d = 1'b1;
            end
        end
    end

    assign wd_expired = (state_q == XFER) && !ram_ready && (wd_cnt_q == WW'(TIMEOUT - 1));
    assign xfer_end   = (state_q == XFER) && (ram_ready || wd_expired);
    // Completion is never reported while reset is being applied.
    assign done_ok    = xfer_end && resetn;

    // A requester that dropped req_valid mid-transfer gets no completion pulse.
    assign req_ready   = done_ok ? (grant_q & req_valid) : '0;
    assign req_rdata   = !done_ok ? '0 : (ram_ready ? ram_rdata : ERR_RDATA);
    assign timeout_err = wd_expired && resetn;

    assign grant     = grant_q;
    assign ram_valid = ram_valid_q;
    assign bus_busy  = |grant_q[NREQ-1:1];

    // Mux keyed on the registered grant, so it cannot change during a transfer.
    always_comb begin
        ram_addr  = '0;
        ram_wdata = '0;
        ram_wstrb = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_q[i]) begin
                ram_addr  = ram_addr  | req_addr[32*i +: 32];
                ram_wdata = ram_wdata | req_wdata[32*i +: 32];
                ram_wstrb = ram_wstrb | req_wstrb[4*i +: 4];
            end
        end
    end

    // NOTE: reset is synchronous, so it is just the first branch of the clocked block; all state uses <=.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            ram_valid_q <= 1'b0;
            rr_ptr_q    <= '0;
            winner_q    <= '0;
            burst_cnt_q <= '0;
            wd_cnt_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_vld_d) begin
                        grant_q     <= NREQ'(1) << pick_d;
                        winner_q    <= pick_d;
                        ram_valid_q <= 1'b1;
                        wd_cnt_q    <= '0;
                        state_q     <= XFER;
                    end
                end
                XFER: begin
                    if (xfer_end) begin
                        ram_valid_q <= 1'b0;
                        wd_cnt_q    <= '0;
                        state_q     <= GAP;
                    end else begin
                        wd_cnt_q <= wd_cnt_q + 1'b1;
                    end
                end
                GAP: begin
                    // ram_valid stays low here for one cycle so the RAM sees a fresh rising edge.
                    if (req_lock[winner_q] && req_valid[winner_q] &&
                        (burst_cnt_q < BW'(MAX_BURST - 1))) begin
                        burst_cnt_q <= burst_cnt_q + 1'b1;
                        ram_valid_q <= 1'b1;
                        state_q     <= XFER;
                    end else begin
                        burst_cnt_q <= '0;
                        rr_ptr_q    <= (winner_q == IW'(NREQ - 1)) ? '0 : winner_q + 1'b1;
                        grant_q     <= '0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/heap_port_arbiter.md
Name: heap_port_arbiter

Overview:
- Shares the single heap RAM port (picorv32-style valid/ready bus, 128 KB block RAM) among NREQ requesters: CPU, DMA RX writer, DMA TX reader.
- Round-robin grant with optional burst lock, bounded by MAX_BURST.
- Inserts the mandatory idle gap that the RAM's valid-rising-edge ready generation requires.
- Includes a watchdog so a hung RAM transaction cannot stall the system.

Parameters:
- NREQ, 3, number of requesters; index 0 = CPU, 1 = DMA RX, 2 = DMA TX.
- MAX_BURST, 16, maximum consecutive locked transfers granted to one requester before forced rotation.
- TIMEOUT, 64, cycles to wait for ram_ready before aborting a transfer.
- ERR_RDATA, 32'hDEAD_BEEF, read data returned on an aborted transfer.

Ports:
- clk  in  1  clock.
- resetn  in  1  reset, synchronous, active-low.
- req_valid  in  NREQ  per-requester request; held high until the matching req_ready.
- req_lock  in  NREQ  per-requester burst lock; when high, keep the grant after completion.
- req_addr  in  NREQ*32  byte address; slice i = [32*i+31:32*i].
- req_wdata  in  NREQ*32  write data.
- req_wstrb  in  NREQ*4  byte strobes; 0 = read.
- req_ready  out  NREQ  one-cycle completion pulse to the granted requester.
- req_rdata  out  32  read data, shared; valid only in the req_ready cycle.
- ram_valid  out  1  request to RAM.
- ram_addr  out  32  muxed address.
- ram_wdata  out  32  muxed write data.
- ram_wstrb  out  4  muxed strobes.
- ram_ready  in  1  RAM completion.
- ram_rdata  in  32  RAM read data.
- grant  out  NREQ  one-hot current owner; 0 when idle.
- bus_busy  out  1  high while any non-CPU requester owns the port (DMA status).
- timeout_err  out  1  one-cycle pulse on abort.

Behaviour:
- Reset values: all outputs 0; rr_ptr = 0; burst_cnt = 0; wd_cnt = 0; state = IDLE.
- States are IDLE, XFER, GAP.

IDLE:
- If any req_valid is set, pick the first set bit searching upward from rr_ptr, wrapping at NREQ.
- Next cycle: grant = one-hot(winner), ram_valid = 1, ram_* driven from the winner's slice, state = XFER.
- Arbitration to ram_valid latency is 1 cycle.

XFER:
- ram_* mux is selected by the registered grant; the mux is stable for the whole transfer.
- wd_cnt increments each cycle.
- On ram_ready:
  - req_ready[winner] = 1 that same cycle (combinational pass-through); req_rdata = ram_rdata.
  - Next cycle: ram_valid = 0, state = GAP, wd_cnt = 0.
- On wd_cnt == TIMEOUT-1 without ram_ready:
  - req_ready[winner] = 1, req_rdata = ERR_RDATA, timeout_err = 1.
  - ram_valid = 0 next cycle, state = GAP.
- A requester dropping req_valid mid-XFER is a protocol violation. The arbiter completes the RAM transfer anyway and suppresses that requester's req_ready.

GAP:
- Exactly 1 cycle with ram_valid = 0. This is required so the RAM sees a fresh valid rising edge.
- Burst continues when req_lock[winner] && req_valid[winner] && burst_cnt < MAX_BURST-1:
  - grant is kept, burst_cnt++, state = XFER, ram_valid = 1.
- Otherwise:
  - burst_cnt = 0, rr_ptr = (winner+1) mod NREQ, grant = 0, state = IDLE.
  - A pending request is then arbitrated in IDLE the next cycle.
- Throughput: minimum per transfer is RAM latency + 1 gap cycle, plus 1 arbitration cycle when not locked.

Other rules:
- Simultaneous requests resolve purely by rr_ptr; no requester ever waits more than (NREQ-1)*MAX_BURST transfers.
- bus_busy = |grant[NREQ-1:1].
- timeout_err only pulses; no sticky state.
- Reset mid-transfer: everything returns to reset values next edge, ram_valid drops, no req_ready is issued.
- Write transfers (wstrb != 0) and reads follow identical sequencing.

Test Plan:
- Single read: CPU reads 0x0002_0010, RAM answers in 2 cycles with 0x1234_5678 -> req_ready[0] pulses once with rdata 0x1234_5678; ram_valid low for 1 cycle afterward; grant returns to 0.
- Contention: all three req_valid rise together, rr_ptr = 0 -> grant order 0, 1, 2, 0; each requester gets exactly one req_ready per round.
- Burst lock: DMA RX holds lock for 20 writes, MAX_BURST = 16 -> 16 back-to-back transfers each separated by 1 gap cycle, then CPU is served, then DMA RX resumes; bus_busy high only during DMA ownership.
- Timeout: RAM never asserts ready, TIMEOUT = 64 -> at cycle 64 of XFER, req_ready pulses with rdata 0xDEAD_BEEF and timeout_err = 1; next request proceeds normally.
- Reset mid-XFER: resetn low during a DMA TX read -> next edge all outputs are 0, no req_ready; after release, a CPU request is granted first (rr_ptr = 0).
- Write strobes: CPU writes wstrb = 4'b0011 to 0x0002_0004 -> ram_wstrb = 0011 and ram_addr passed through unchanged for the full XFER; no strobe leakage from other requesters.
